char_load_arbiter: RTL and testbench
====================================

Name: char_load_arbiter

Overview:
- Owns the single data-RAM port and shares it between three masters: the host character loader, the processor, and host read-back. Replaces the ad-hoc wrapper muxing and free-running write counter.
- Adds the following over the previous arrangement:
  - mode synchroniser;
  - valid/ready load handshake;
  - parametrised buffer base/depth with full, wrap and overflow handling;
  - clearable load pointer;
  - processor reset sequencing with an exec_start pulse.
- Sits between board I/O (switches/buttons) and the processor + RAM in the top-level wrapper.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 32, RAM data width.
- CHAR_W, 8, loaded character width (CHAR_W <= DATA_W).
- BUF_BASE, 1500, first RAM address of the character buffer.
- BUF_DEPTH, 108, buffer size in entries (12x9); BUF_BASE+BUF_DEPTH <= 2**ADDR_W.
- WRAP, 0, 0 = refuse writes when full; 1 = wrap pointer to 0 and set overflow.
- CNT_W, $clog2(BUF_DEPTH+1), width of ld_count.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- mode, input, 2, raw switch mode (asynchronous to clock): 00 IDLE, 01 LOAD, 10 EXEC, 11 READ.
- ld_valid, input, 1, host character valid.
- ld_data, input, CHAR_W, host character.
- ld_ready, output, 1, arbiter accepts a character this cycle.
- ld_clear, input, 1, synchronous pointer/flag clear.
- ld_count, output, CNT_W, characters currently held (saturates at BUF_DEPTH).
- ld_full, output, 1, ld_count == BUF_DEPTH.
- ld_overflow, output, 1, sticky: a write wrapped (WRAP=1 only).
- last_char, output, CHAR_W, last accepted character (LED display).
- cpu_addr, input, ADDR_W, processor RAM address.
- cpu_wdata, input, DATA_W, processor RAM write data.
- cpu_wen, input, 1, processor RAM write enable.
- cpu_reset, output, 1, active-high reset to processor.
- exec_start, output, 1, one-cycle pulse when the processor is released.
- rd_addr, input, ADDR_W, host read-back address.
- ram_addr, output, ADDR_W, RAM address.
- ram_wdata, output, DATA_W, RAM write data.
- ram_wen, output, 1, RAM write enable.
- state, output, 2, current state (debug).

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, both sync flops=00, ptr=0, ld_count=0, ld_overflow=0, last_char=0, cpu_reset=1, exec_start=0.
- Mode synchroniser: mode passes through 2 flops; state loads the synchronised value on the next edge. Mode change to state change is 3 edges. Any state-to-state transition is legal.
- State-dependent RAM port routing (ram_* are combinational from registered state):
  - IDLE: ram_wen=0, ram_addr=0, ram_wdata=0.
  - LOAD: ram_addr=BUF_BASE+ptr, ram_wdata=zero-extended ld_data, ram_wen=ld_valid&ld_ready.
  - EXEC: ram_* = cpu_* directly.
  - READ: ram_addr=rd_addr, ram_wen=0. The host takes RAM q 1 cycle later (synchronous-read RAM).
- ld_ready = (state==LOAD) & ~ld_clear & (~ld_full | WRAP). Outside LOAD, ld_ready=0 and ld_valid is ignored.
- Accepted write (ld_valid & ld_ready):
  - last_char <= ld_data.
  - If ptr==BUF_DEPTH-1, ptr <= 0; otherwise ptr <= ptr+1.
  - ld_count <= min(ld_count+1, BUF_DEPTH).
  - If WRAP and ld_full, ld_overflow <= 1.
- WRAP=0 full: ld_ready=0, ptr holds at BUF_DEPTH (address never exceeds BUF_BASE+BUF_DEPTH-1 on an accepted write).
- ld_clear (any state): ptr, ld_count, ld_overflow <= 0 next edge. ld_clear has priority over a simultaneous write, which is blocked via ld_ready.
- ptr/count persist across mode changes. Re-entering LOAD appends.
- Processor sequencing:
  - cpu_reset=1 in every state except EXEC.
  - On the first cycle in EXEC, cpu_reset stays 1.
  - On the second cycle, cpu_reset drops to 0 and exec_start=1 for exactly one cycle.
  - Leaving EXEC sets cpu_reset=1 on the same edge the state changes.
  - cpu_wen outside EXEC never reaches ram_wen.
- EXEC->LOAD->EXEC yields a fresh processor reset and a second exec_start pulse.

Decomposition:
- Shared package: mode/state encodings (IDLE, LOAD, EXEC, READ) and defaults BUF_BASE=1500, BUF_DEPTH=108. The existing wrapper and this block both use them.
- One natural sub-module: sync_2ff (parametrised-width two-flop synchroniser, active-low async reset) for mode; reusable for other switch inputs.

Test Plan:
- Reset mid-LOAD after 5 writes -> all outputs return to reset values immediately (asynchronous); after release, the first write goes to address 1500.
- mode=01, stream 'H','I','!' with ld_valid held -> after 3 sync edges, RAM writes 0x48@1500, 0x49@1501, 0x21@1502; ld_count=3; last_char=0x21.
- WRAP=0, BUF_DEPTH=4, 6 chars -> 4 writes (addr 1500-1503), ld_full=1, ld_ready=0, chars 5-6 dropped, count=4. WRAP=1 -> 5th char writes 1500, ld_overflow=1, count stays 4.
- ld_clear asserted together with ld_valid at count=2 -> no write that cycle; next accepted char goes to 1500; count=1.
- mode 01->10 -> cpu_reset=1 through 3 sync edges plus one EXEC cycle, then 0 with a single exec_start pulse. cpu_wen=1/addr 7/data 0xDEAD appears on ram_*. cpu_wen while in LOAD never asserts ram_wen.
- mode=11, rd_addr=1501 after the load test -> ram_wen=0, ram_addr=1501, RAM q = 0x49 one cycle later. Switching back to EXEC re-pulses exec_start.

Source files
------------

// File: rtl/char_load_arbiter_pkg.sv
// Shared encodings and buffer defaults for the character-load arbiter and the
// board wrapper that drives it.
package char_load_arbiter_pkg;

  // Switch mode and arbiter state share one encoding.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_EXEC = 2'b10;
  localparam logic [1:0] ST_READ = 2'b11;

  localparam int DEF_BUF_BASE  = 1500;
  localparam int DEF_BUF_DEPTH = 108;   // 12 x 9 character grid

endpackage

// File: rtl/char_load_arbiter_sync_2ff.sv
// Two-flop synchroniser for slow asynchronous inputs such as board switches.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state always uses non-blocking assignments so both flops
  // sample the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/char_load_arbiter.sv
// Arbitrates the single data-RAM port between the host character loader, the
// processor and host read-back, and sequences the processor reset.
module char_load_arbiter
  import char_load_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int CHAR_W    = 8,
  parameter int BUF_BASE  = DEF_BUF_BASE,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int WRAP      = 0,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              ld_valid,
  input  logic [CHAR_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_clear,
  output logic [CNT_W-1:0]  ld_count,
  output logic              ld_full,
  output logic              ld_overflow,
  output logic [CHAR_W-1:0] last_char,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wen,
  output logic              cpu_reset,
  output logic              exec_start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wen,
  output logic [1:0]        state
);

  localparam logic WRAP_EN = (WRAP != 0);

  logic [1:0]       mode_sync;
  logic [CNT_W-1:0] ptr;
  logic             accept;
  logic             ptr_at_end;
  logic             exec_hold;

  sync_2ff #(.WIDTH(2)) u_mode_sync (
    .clk   (clock),
    .rst_n (reset),
    .d     (mode),
    .q     (mode_sync)
  );

  assign ld_full    = (ld_count == CNT_W'(BUF_DEPTH));
  assign ld_ready   = (state == ST_LOAD) & ~ld_clear & (~ld_full | WRAP_EN);
  assign accept     = ld_valid & ld_ready;
  assign ptr_at_end = (ptr == CNT_W'(BUF_DEPTH - 1));

  // Processor is released only while EXEC is both current and next state.
  assign exec_hold  = (state == ST_EXEC) && (mode_sync == ST_EXEC);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      ld_count    <= '0;
      ld_overflow <= 1'b0;
      last_char   <= '0;
      cpu_reset   <= 1'b1;
      exec_start  <= 1'b0;
    end else begin
      state      <= mode_sync;
      cpu_reset  <= ~exec_hold;
      exec_start <= exec_hold & cpu_reset;

      if (accept) last_char <= ld_data;

      if (ld_clear) begin
        ptr         <= '0;
        ld_count    <= '0;
        ld_overflow <= 1'b0;
      end else if (accept) begin
        // Without WRAP the pointer runs on to BUF_DEPTH and parks there; the
        // full flag then blocks ld_ready so that address is never written.
        ptr <= (WRAP_EN && ptr_at_end) ? '0 : ptr + 1'b1;
        if (!ld_full) ld_count <= ld_count + 1'b1;
        if (WRAP_EN && ld_full) ld_overflow <= 1'b1;
      end
    end
  end

  // NOTE: every output gets a default before the case so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wen   = 1'b0;
    case (state)
      ST_LOAD: begin
        ram_addr  = ADDR_W'(BUF_BASE) + ADDR_W'(ptr);
        ram_wdata = DATA_W'(ld_data);
        ram_wen   = accept;
      end
      ST_EXEC: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_wen   = cpu_wen;
      end
      ST_READ: ram_addr = rd_addr;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_char_load_arbiter.sv
// Directed bench: two depth-4 arbiters (refuse-when-full and wrap) share one
// stimulus stream; the refuse instance also drives a small synchronous RAM.
module tb_char_load_arbiter;
  import char_load_arbiter_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [11:0] B     = 12'd1500;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        ld_valid, ld_clear, cpu_wen;
  logic [7:0]  ld_data;
  logic [11:0] cpu_addr, rd_addr;
  logic [31:0] cpu_wdata;

  logic        ld_ready_0, ld_full_0, ld_overflow_0, cpu_reset_0, exec_start_0, ram_wen_0;
  logic [2:0]  ld_count_0;
  logic [7:0]  last_char_0;
  logic [11:0] ram_addr_0;
  logic [31:0] ram_wdata_0;
  logic [1:0]  state_0;

  logic        ld_ready_1, ld_full_1, ld_overflow_1, cpu_reset_1, exec_start_1, ram_wen_1;
  logic [2:0]  ld_count_1;
  logic [7:0]  last_char_1;
  logic [11:0] ram_addr_1;
  logic [31:0] ram_wdata_1;
  logic [1:0]  state_1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  char_load_arbiter #(.BUF_DEPTH(DEPTH), .WRAP(0)) u_dut0 (
    .clock(clock), .reset(reset), .mode(mode),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_0), .ld_clear(ld_clear),
    .ld_count(ld_count_0), .ld_full(ld_full_0), .ld_overflow(ld_overflow_0),
    .last_char(last_char_0), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen),
    .cpu_reset(cpu_reset_0), .exec_start(exec_start_0), .rd_addr(rd_addr),
    .ram_addr(ram_addr_0), .ram_wdata(ram_wdata_0), .ram_wen(ram_wen_0), .state(state_0)
  );

  char_load_arbiter #(.BUF_DEPTH(DEPTH), .WRAP(1)) u_dut1 (
    .clock(clock), .reset(reset), .mode(mode),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_1), .ld_clear(ld_clear),
    .ld_count(ld_count_1), .ld_full(ld_full_1), .ld_overflow(ld_overflow_1),
    .last_char(last_char_1), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen),
    .cpu_reset(cpu_reset_1), .exec_start(exec_start_1), .rd_addr(rd_addr),
    .ram_addr(ram_addr_1), .ram_wdata(ram_wdata_1), .ram_wen(ram_wen_1), .state(state_1)
  );

  // Synchronous-read RAM on the refuse instance's port.
  logic [31:0] mem [4096];
  logic [31:0] ram_q;
  always @(posedge clock) begin
    if (ram_wen_0) mem[ram_addr_0] <= ram_wdata_0;
    ram_q <= mem[ram_addr_0];
  end

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        clr;
    logic        rdy0;
    logic        wen0;
    logic [11:0] addr0;
    logic [2:0]  cnt0;
    logic        full0;
    logic [7:0]  last0;
    logic        wen1;
    logic [11:0] addr1;
    logic [2:0]  cnt1;
    logic        full1;
    logic        ovf1;
    logic [7:0]  last1;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic valid, input logic [7:0] data, input logic clr,
    input logic rdy0, input logic wen0, input logic [11:0] addr0, input logic [2:0] cnt0,
    input logic full0, input logic [7:0] last0,
    input logic wen1, input logic [11:0] addr1, input logic [2:0] cnt1,
    input logic full1, input logic ovf1, input logic [7:0] last1);
    vec_t v;
    v.valid = valid; v.data = data; v.clr = clr;
    v.rdy0 = rdy0; v.wen0 = wen0; v.addr0 = addr0; v.cnt0 = cnt0; v.full0 = full0; v.last0 = last0;
    v.wen1 = wen1; v.addr1 = addr1; v.cnt1 = cnt1; v.full1 = full1; v.ovf1 = ovf1; v.last1 = last1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector, check the combinational port, clock it, check state.
  task automatic apply(input int i);
    vec_t v;
    v = vecs[i];
    ld_valid = v.valid;
    ld_data  = v.data;
    ld_clear = v.clr;
    #2;
    check($sformatf("v%0d ld_ready0", i), {31'b0, ld_ready_0}, {31'b0, v.rdy0});
    check($sformatf("v%0d ram_wen0", i), {31'b0, ram_wen_0}, {31'b0, v.wen0});
    if (v.wen0) begin
      check($sformatf("v%0d ram_addr0", i), {20'b0, ram_addr_0}, {20'b0, v.addr0});
      check($sformatf("v%0d ram_wdata0", i), ram_wdata_0, {24'b0, v.data});
    end
    check($sformatf("v%0d ram_wen1", i), {31'b0, ram_wen_1}, {31'b0, v.wen1});
    if (v.wen1) check($sformatf("v%0d ram_addr1", i), {20'b0, ram_addr_1}, {20'b0, v.addr1});
    @(posedge clock); #1;
    check($sformatf("v%0d count0", i), {29'b0, ld_count_0}, {29'b0, v.cnt0});
    check($sformatf("v%0d full0", i), {31'b0, ld_full_0}, {31'b0, v.full0});
    check($sformatf("v%0d ovf0", i), {31'b0, ld_overflow_0}, 32'd0);
    check($sformatf("v%0d last0", i), {24'b0, last_char_0}, {24'b0, v.last0});
    check($sformatf("v%0d count1", i), {29'b0, ld_count_1}, {29'b0, v.cnt1});
    check($sformatf("v%0d full1", i), {31'b0, ld_full_1}, {31'b0, v.full1});
    check($sformatf("v%0d ovf1", i), {31'b0, ld_overflow_1}, {31'b0, v.ovf1});
    check($sformatf("v%0d last1", i), {24'b0, last_char_1}, {24'b0, v.last1});
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int first;

    //                 v  data   clr rdy wen addr  c  f  last   | wen addr  c  f  ovf last
    vecs[0]  = mk(1, 8'h70, 0,  1,  1, B,    1, 0, 8'h70,   1, B,    1, 0, 0, 8'h70);
    vecs[1]  = mk(1, 8'h71, 0,  1,  1, B+1,  2, 0, 8'h71,   1, B+1,  2, 0, 0, 8'h71);
    vecs[2]  = mk(1, 8'h78, 1,  0,  0, B,    0, 0, 8'h71,   0, B,    0, 0, 0, 8'h71);
    vecs[3]  = mk(1, 8'h72, 0,  1,  1, B,    1, 0, 8'h72,   1, B,    1, 0, 0, 8'h72);
    vecs[4]  = mk(0, 8'h00, 1,  0,  0, B,    0, 0, 8'h72,   0, B,    0, 0, 0, 8'h72);
    vecs[5]  = mk(1, 8'h61, 0,  1,  1, B,    1, 0, 8'h61,   1, B,    1, 0, 0, 8'h61);
    vecs[6]  = mk(1, 8'h62, 0,  1,  1, B+1,  2, 0, 8'h62,   1, B+1,  2, 0, 0, 8'h62);
    vecs[7]  = mk(1, 8'h63, 0,  1,  1, B+2,  3, 0, 8'h63,   1, B+2,  3, 0, 0, 8'h63);
    vecs[8]  = mk(1, 8'h64, 0,  1,  1, B+3,  4, 1, 8'h64,   1, B+3,  4, 1, 0, 8'h64);
    vecs[9]  = mk(1, 8'h65, 0,  0,  0, B,    4, 1, 8'h64,   1, B,    4, 1, 1, 8'h65);
    vecs[10] = mk(1, 8'h66, 0,  0,  0, B,    4, 1, 8'h64,   1, B+1,  4, 1, 1, 8'h66);
    vecs[11] = mk(1, 8'h48, 0,  1,  1, B,    1, 0, 8'h48,   1, B,    1, 0, 0, 8'h48);
    vecs[12] = mk(1, 8'h49, 0,  1,  1, B+1,  2, 0, 8'h49,   1, B+1,  2, 0, 0, 8'h49);
    vecs[13] = mk(1, 8'h21, 0,  1,  1, B+2,  3, 0, 8'h21,   1, B+2,  3, 0, 0, 8'h21);
    vecs[14] = mk(0, 8'h00, 0,  1,  0, B,    3, 0, 8'h21,   0, B,    3, 0, 0, 8'h21);

    mode = ST_IDLE; ld_valid = 0; ld_data = 0; ld_clear = 0;
    cpu_addr = 0; cpu_wdata = 0; cpu_wen = 0; rd_addr = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst state", {30'b0, state_0}, {30'b0, ST_IDLE});
    check("rst cpu_reset", {31'b0, cpu_reset_0}, 32'd1);
    check("rst exec_start", {31'b0, exec_start_0}, 32'd0);
    check("rst count", {29'b0, ld_count_0}, 32'd0);
    check("rst last_char", {24'b0, last_char_0}, 32'd0);
    check("rst ram_wen", {31'b0, ram_wen_0}, 32'd0);
    check("rst ram_addr", {20'b0, ram_addr_0}, 32'd0);
    check("rst ovf1", {31'b0, ld_overflow_1}, 32'd0);

    edges(2);
    reset = 1'b1;
    mode  = ST_LOAD;
    edges(2);
    check("sync 2 edges still idle", {30'b0, state_0}, {30'b0, ST_IDLE});
    edges(1);
    check("sync 3rd edge load", {30'b0, state_0}, {30'b0, ST_LOAD});
    check("sync 3rd edge load w1", {30'b0, state_1}, {30'b0, ST_LOAD});

    // Clear priority, fill to full, refuse vs wrap.
    for (int i = 0; i <= 10; i++) apply(i);

    // Asynchronous reset mid-cycle while loaded.
    @(negedge clock); #2;
    reset = 1'b0;
    #1;
    check("areset state", {30'b0, state_0}, {30'b0, ST_IDLE});
    check("areset count0", {29'b0, ld_count_0}, 32'd0);
    check("areset full0", {31'b0, ld_full_0}, 32'd0);
    check("areset last0", {24'b0, last_char_0}, 32'd0);
    check("areset ram_wen", {31'b0, ram_wen_0}, 32'd0);
    check("areset cpu_reset", {31'b0, cpu_reset_0}, 32'd1);
    check("areset ovf1", {31'b0, ld_overflow_1}, 32'd0);
    check("areset count1", {29'b0, ld_count_1}, 32'd0);
    @(posedge clock); #1;
    reset    = 1'b1;
    ld_valid = 1'b0;
    edges(3);
    check("resync load", {30'b0, state_0}, {30'b0, ST_LOAD});

    // "HI!" load; first write after reset lands on the buffer base.
    for (int i = 11; i <= 14; i++) apply(i);

    cpu_wen = 1'b1; cpu_addr = 12'd7; cpu_wdata = 32'hDEAD;
    #1;
    check("load blocks cpu_wen", {31'b0, ram_wen_0}, 32'd0);
    check("load addr at ptr", {20'b0, ram_addr_0}, {20'b0, B + 12'd3});

    // LOAD -> EXEC: reset held through sync plus one EXEC cycle.
    mode = ST_EXEC;
    for (int e = 1; e <= 2; e++) begin
      edges(1);
      check($sformatf("exec e%0d state", e), {30'b0, state_0}, {30'b0, ST_LOAD});
      check($sformatf("exec e%0d cpu_reset", e), {31'b0, cpu_reset_0}, 32'd1);
      check($sformatf("exec e%0d ram_wen", e), {31'b0, ram_wen_0}, 32'd0);
    end
    edges(1);
    check("exec e3 state", {30'b0, state_0}, {30'b0, ST_EXEC});
    check("exec e3 cpu_reset", {31'b0, cpu_reset_0}, 32'd1);
    check("exec e3 exec_start", {31'b0, exec_start_0}, 32'd0);
    check("exec ram_wen", {31'b0, ram_wen_0}, 32'd1);
    check("exec ram_addr", {20'b0, ram_addr_0}, 32'd7);
    check("exec ram_wdata", ram_wdata_0, 32'hDEAD);
    edges(1);
    check("exec e4 cpu_reset", {31'b0, cpu_reset_0}, 32'd0);
    check("exec e4 exec_start", {31'b0, exec_start_0}, 32'd1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      edges(1);
      if (exec_start_0) pulses++;
    end
    check("exec no repulse", pulses, 32'd0);
    check("exec cpu_reset stays low", {31'b0, cpu_reset_0}, 32'd0);
    check("exec count kept", {29'b0, ld_count_0}, 32'd3);

    // EXEC -> READ: read back the 'I' at 1501.
    mode = ST_READ; rd_addr = B + 12'd1; ld_valid = 1'b1; ld_data = 8'h55;
    edges(2);
    check("read pre cpu_reset", {31'b0, cpu_reset_0}, 32'd0);
    edges(1);
    check("read state", {30'b0, state_0}, {30'b0, ST_READ});
    check("read cpu_reset", {31'b0, cpu_reset_0}, 32'd1);
    check("read ram_wen", {31'b0, ram_wen_0}, 32'd0);
    check("read ram_addr", {20'b0, ram_addr_0}, {20'b0, B + 12'd1});
    check("read ld_ready", {31'b0, ld_ready_0}, 32'd0);
    edges(1);
    check("read q", ram_q, 32'h49);
    ld_valid = 1'b0;

    // READ -> EXEC: second processor release.
    mode = ST_EXEC;
    pulses = 0; first = -1;
    for (int k = 1; k <= 8; k++) begin
      edges(1);
      if (exec_start_0) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check("reexec pulses", pulses, 32'd1);
    check("reexec pulse edge", first, 32'd4);

    // IDLE: port parked, clear still works outside LOAD.
    mode = ST_IDLE;
    edges(3);
    check("idle state", {30'b0, state_0}, {30'b0, ST_IDLE});
    check("idle ram_wen", {31'b0, ram_wen_0}, 32'd0);
    check("idle ram_addr", {20'b0, ram_addr_0}, 32'd0);
    check("idle ram_wdata", ram_wdata_0, 32'd0);
    check("idle cpu_reset", {31'b0, cpu_reset_0}, 32'd1);
    check("idle count kept", {29'b0, ld_count_0}, 32'd3);
    ld_clear = 1'b1;
    edges(1);
    ld_clear = 1'b0;
    check("idle clear count0", {29'b0, ld_count_0}, 32'd0);
    check("idle clear count1", {29'b0, ld_count_1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
